// File: rtl/voxel_memory_banked.sv
// Banked multi-port voxel store: NUM_RD round-robin read ports, byte-masked write port, full-volume clear engine.
// Optional bank-conflict statistics are enabled with `define VOXEL_MEM_CONFLICT_STATS_EN.
module voxel_memory_banked #(
  parameter int                    DATA_WIDTH  = 64,
  parameter int                    COORD_BITS  = 6,
  parameter int                    NUM_RD      = 2,
  parameter int                    BANK_BITS   = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic [NUM_RD-1:0]              rd_valid,
  input  logic [NUM_RD*3*COORD_BITS-1:0] rd_addr,
  output logic [NUM_RD-1:0]              rd_ready,
  output logic [NUM_RD-1:0]              rsp_valid,
  output logic [NUM_RD*DATA_WIDTH-1:0]   rsp_data,
  input  logic                           wr_valid,
  output logic                           wr_ready,
  input  logic [3*COORD_BITS-1:0]        wr_addr,
  input  logic [DATA_WIDTH-1:0]          wr_data,
  input  logic [DATA_WIDTH/8-1:0]        wr_be,
  input  logic                           clear_start,
  output logic                           busy,
  output logic [31:0]                    conflict_count
);

  localparam int ADDR_WIDTH = 3*COORD_BITS;
  localparam int NB         = 1 << BANK_BITS;
  localparam int RW         = ADDR_WIDTH - BANK_BITS;
  localparam int ROWS       = 1 << RW;
  localparam int NBYTE      = DATA_WIDTH/8;
  localparam int PW         = (NUM_RD > 1) ? $clog2(NUM_RD) : 1;

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t                             state, state_nxt;
  logic [RW-1:0]                      clr_row, clr_row_nxt;
  logic                               req_en;
  logic                               wr_fire;
  logic [BANK_BITS-1:0]               wr_bank;
  logic [RW-1:0]                      wr_row;

  logic [NUM_RD-1:0][BANK_BITS-1:0]   port_bank;
  logic [NUM_RD-1:0][RW-1:0]          port_row;
  logic [NB-1:0][PW-1:0]              ptr;
  logic [NB-1:0]                      bank_hit;
  logic [NB-1:0][PW-1:0]              bank_port;
  logic [PW-1:0]                      rr_idx;
  logic [NUM_RD-1:0]                  grant;

  logic [NUM_RD-1:0]                  vld_p0, vld_p1;
  logic [NUM_RD-1:0][BANK_BITS-1:0]   bank_p0, bank_p1;
  logic [NB-1:0]                      rd_en_p0;
  logic [NB-1:0][RW-1:0]              row_p0;
  logic [NB-1:0][DATA_WIDTH-1:0]      dout_p1;

  assign req_en   = (state == IDLE) && !clear_start;
  assign busy     = (state == CLEAR);
  assign wr_ready = req_en;
  assign wr_fire  = wr_valid && wr_ready;
  assign wr_bank  = wr_addr[BANK_BITS-1:0];
  assign wr_row   = wr_addr[ADDR_WIDTH-1:BANK_BITS];
  assign rd_ready = grant;

  always_comb begin
    port_bank = '0;
    port_row  = '0;
    for (int p = 0; p < NUM_RD; p++) begin
      port_bank[p] = rd_addr[p*ADDR_WIDTH +: BANK_BITS];
      port_row[p]  = rd_addr[p*ADDR_WIDTH+BANK_BITS +: RW];
    end
  end

  // Per-bank round-robin: scan from the port after the last winner, first requester wins.
  always_comb begin
    grant     = '0;
    bank_hit  = '0;
    bank_port = '0;
    rr_idx    = '0;
    for (int b = 0; b < NB; b++) begin
      for (int k = 0; k < NUM_RD; k++) begin
        rr_idx = PW'((int'(ptr[b]) + 1 + k) % NUM_RD);
        if (req_en && !bank_hit[b] && rd_valid[rr_idx] &&
            port_bank[rr_idx] == BANK_BITS'(b)) begin
          bank_hit[b]    = 1'b1;
          bank_port[b]   = rr_idx;
          grant[rr_idx]  = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_nxt   = state;
    clr_row_nxt = clr_row;
    case (state)
      IDLE: begin
        if (clear_start) state_nxt = CLEAR;
      end
      CLEAR: begin
        if (clr_row == '1) begin
          state_nxt   = IDLE;
          clr_row_nxt = '0;
        end else begin
          clr_row_nxt = clr_row + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      clr_row   <= '0;
      ptr       <= '0;
      vld_p0    <= '0;
      rd_en_p0  <= '0;
      vld_p1    <= '0;
      rsp_valid <= '0;
      rsp_data  <= '0;
    end else begin
      state    <= state_nxt;
      clr_row  <= clr_row_nxt;
      for (int b = 0; b < NB; b++) begin
        if (bank_hit[b]) ptr[b] <= bank_port[b];
      end
      // p0: request accepted
      vld_p0   <= grant;
      rd_en_p0 <= bank_hit;
      // p1: bank RAM output
      vld_p1   <= vld_p0;
      // p2: response register
      rsp_valid <= vld_p1;
      for (int p = 0; p < NUM_RD; p++) begin
        if (vld_p1[p]) rsp_data[p*DATA_WIDTH +: DATA_WIDTH] <= dout_p1[bank_p1[p]];
      end
    end
  end

  always_ff @(posedge clk) begin
    bank_p0 <= port_bank;
    bank_p1 <= bank_p0;
    for (int b = 0; b < NB; b++) begin
      row_p0[b] <= port_row[bank_port[b]];
    end
  end

  // Byte-lane RAMs: a write at edge T is visible to the row read at T+1, which
  // gives write-first behaviour for reads accepted at T without a bypass path.
  for (genvar b = 0; b < NB; b++) begin : g_bank
    for (genvar i = 0; i < NBYTE; i++) begin : g_lane
      logic [7:0] mem [ROWS];
      logic [7:0] q_p1;
      always_ff @(posedge clk) begin
        if (state == CLEAR) begin
          mem[clr_row] <= CLEAR_VALUE[i*8 +: 8];
        end else if (wr_fire && wr_bank == BANK_BITS'(b) && wr_be[i]) begin
          mem[wr_row] <= wr_data[i*8 +: 8];
        end
        if (rd_en_p0[b]) q_p1 <= mem[row_p0[b]];
      end
      assign dout_p1[b][i*8 +: 8] = q_p1;
    end
  end

`ifdef VOXEL_MEM_CONFLICT_STATS_EN
  logic [NUM_RD-1:0] losers;
  logic [31:0]       conflict_cnt;

  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] inc);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, inc};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

  assign losers = rd_valid & ~grant & {NUM_RD{req_en}};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) conflict_cnt <= '0;
    else        conflict_cnt <= sat_add32(conflict_cnt, 32'($countones(losers)));
  end

  assign conflict_count = conflict_cnt;
`else
  assign conflict_count = 32'd0;
`endif

endmodule

// File: tb/tb_voxel_memory_banked.sv
// Directed bench for voxel_memory_banked on a reduced 16^3 grid (2048 rows per bank, 2 banks).
module tb_voxel_memory_banked;
  localparam int DW   = 64;
  localparam int CB   = 4;
  localparam int NR   = 2;
  localparam int BB   = 1;
  localparam int AW   = 3*CB;
  localparam int ROWS = 2048;
  localparam logic [63:0] CLRV = 64'hDEAD;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [NR-1:0]     rd_valid;
  logic [NR*AW-1:0]  rd_addr;
  logic [NR-1:0]     rd_ready;
  logic [NR-1:0]     rsp_valid;
  logic [NR*DW-1:0]  rsp_data;
  logic              wr_valid;
  logic              wr_ready;
  logic [AW-1:0]     wr_addr;
  logic [DW-1:0]     wr_data;
  logic [DW/8-1:0]   wr_be;
  logic              clear_start;
  logic              busy;
  logic [31:0]       conflict_count;

  int total = 0;
  int fails = 0;
  int cnt;
  int bad;
  logic [31:0] exp_conf;

  always #5 clk = ~clk;

  voxel_memory_banked #(
    .DATA_WIDTH(DW), .COORD_BITS(CB), .NUM_RD(NR), .BANK_BITS(BB), .CLEAR_VALUE(CLRV)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_ready(rd_ready),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr),
    .wr_data(wr_data), .wr_be(wr_be),
    .clear_start(clear_start), .busy(busy), .conflict_count(conflict_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [1:0] v, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_valid = v;
    rd_addr  = {a1, a0};
  endtask

  task automatic do_write(input logic [AW-1:0] a, input logic [63:0] d, input logic [7:0] be);
    wr_valid = 1'b1;
    wr_addr  = a;
    wr_data  = d;
    wr_be    = be;
    tick();
    wr_valid = 1'b0;
  endtask

  initial begin
`ifdef VOXEL_MEM_CONFLICT_STATS_EN
    exp_conf = 32'd4;
`else
    exp_conf = 32'd0;
`endif
    rst_n = 1'b0; rd_valid = '0; rd_addr = '0; wr_valid = 1'b0; wr_addr = '0;
    wr_data = '0; wr_be = '0; clear_start = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_rsp_valid", 64'(rsp_valid), 64'd0);
    chk("rst_rsp_data0", rsp_data[63:0], 64'd0);
    chk("rst_rsp_data1", rsp_data[127:64], 64'd0);
    chk("rst_conflict", 64'(conflict_count), 64'd0);
    rst_n = 1'b1;
    tick();

    // Full-word write then read on port 0 (bank 1)
    wr_valid = 1'b1; wr_addr = 12'h105; wr_data = 64'h1122334455667788; wr_be = 8'hFF;
    #1 chk("t1_wr_ready", 64'(wr_ready), 64'd1);
    tick();
    wr_valid = 1'b0;
    set_rd(2'b01, 12'h105, 12'h000);
    #1 chk("t1_rd_ready", 64'(rd_ready), 64'h1);
    tick();
    set_rd(2'b00, 12'h000, 12'h000);
    chk("t1_lat0", 64'(rsp_valid), 64'h0);
    tick();
    chk("t1_lat1", 64'(rsp_valid), 64'h0);
    tick();
    chk("t1_rsp_valid", 64'(rsp_valid), 64'h1);
    chk("t1_rsp_data", rsp_data[63:0], 64'h1122334455667788);
    tick();
    chk("t1_one_cycle", 64'(rsp_valid), 64'h0);

    // Same-edge partial write and port-1 read of the same address
    do_write(12'h200, 64'h0, 8'hFF);
    wr_valid = 1'b1; wr_addr = 12'h200; wr_data = 64'hAAAAAAAABBBBBBBB; wr_be = 8'h0F;
    set_rd(2'b10, 12'h000, 12'h200);
    #1 chk("t2_rd_ready", 64'(rd_ready), 64'h2);
    tick();
    wr_valid = 1'b0;
    set_rd(2'b00, 12'h000, 12'h000);
    tick();
    tick();
    chk("t2_rsp_valid", 64'(rsp_valid), 64'h2);
    chk("t2_fwd_data", rsp_data[127:64], 64'h00000000BBBBBBBB);

    // Bank-0 conflict: bank-0 pointer now sits at port 1, so port 0 wins first
    do_write(12'h002, 64'h2222222222222222, 8'hFF);
    do_write(12'h004, 64'h4444444444444444, 8'hFF);
    do_write(12'h003, 64'h3333333333333333, 8'hFF);
    set_rd(2'b11, 12'h002, 12'h004);
    #1 chk("t3_grant1", 64'(rd_ready), 64'h1);
    tick();
    chk("t3_grant2", 64'(rd_ready), 64'h2);
    tick();
    chk("t3_grant3", 64'(rd_ready), 64'h1);
    tick();
    chk("t3_rsp1_valid", 64'(rsp_valid), 64'h1);
    chk("t3_rsp1_data", rsp_data[63:0], 64'h2222222222222222);
    chk("t3_grant4", 64'(rd_ready), 64'h2);
    tick();
    set_rd(2'b00, 12'h000, 12'h000);
    chk("t3_rsp2_valid", 64'(rsp_valid), 64'h2);
    chk("t3_rsp2_data", rsp_data[127:64], 64'h4444444444444444);
    tick();
    chk("t3_rsp3_valid", 64'(rsp_valid), 64'h1);
    tick();
    chk("t3_rsp4_valid", 64'(rsp_valid), 64'h2);
    chk("t3_conflict", 64'(conflict_count), 64'(exp_conf));
    tick();
    chk("t3_hold_valid", 64'(rsp_valid), 64'h0);
    chk("t3_hold_data0", rsp_data[63:0], 64'h2222222222222222);
    chk("t3_hold_data1", rsp_data[127:64], 64'h4444444444444444);

    // Different banks in the same cycle
    set_rd(2'b11, 12'h002, 12'h003);
    #1 chk("t4_rd_ready", 64'(rd_ready), 64'h3);
    tick();
    set_rd(2'b00, 12'h000, 12'h000);
    tick();
    tick();
    chk("t4_rsp_valid", 64'(rsp_valid), 64'h3);
    chk("t4_data0", rsp_data[63:0], 64'h2222222222222222);
    chk("t4_data1", rsp_data[127:64], 64'h3333333333333333);

    // Clear with requests held throughout
    clear_start = 1'b1;
    set_rd(2'b01, 12'h002, 12'h000);
    wr_valid = 1'b1; wr_addr = 12'h002; wr_data = 64'h5555; wr_be = 8'hFF;
    #1 chk("t5_start_rd_ready", 64'(rd_ready), 64'h0);
    chk("t5_start_wr_ready", 64'(wr_ready), 64'h0);
    chk("t5_start_busy", 64'(busy), 64'h0);
    tick();
    clear_start = 1'b0;
    chk("t5_busy_rise", 64'(busy), 64'h1);
    cnt = 0;
    bad = 0;
    while (busy === 1'b1 && cnt < ROWS + 16) begin
      if (rd_ready !== 2'b00 || wr_ready !== 1'b0) bad++;
      cnt++;
      tick();
    end
    wr_valid = 1'b0;
    chk("t5_busy_cycles", 64'(cnt), 64'(ROWS));
    chk("t5_stall_ready", 64'(bad), 64'd0);
    chk("t5_conflict_unchanged", 64'(conflict_count), 64'(exp_conf));
    set_rd(2'b11, 12'h000, 12'hFFF);
    #1 chk("t5_rd_ready", 64'(rd_ready), 64'h3);
    tick();
    set_rd(2'b00, 12'h000, 12'h000);
    tick();
    tick();
    chk("t5_rsp_valid", 64'(rsp_valid), 64'h3);
    chk("t5_clr_lo", rsp_data[63:0], CLRV);
    chk("t5_clr_hi", rsp_data[127:64], CLRV);

    // Asynchronous reset mid-clear
    clear_start = 1'b1;
    tick();
    clear_start = 1'b0;
    repeat (1000) tick();
    chk("t6_busy_mid", 64'(busy), 64'h1);
    #2 rst_n = 1'b0;
    #1 chk("t6_busy_abort", 64'(busy), 64'h0);
    chk("t6_rsp_valid_abort", 64'(rsp_valid), 64'h0);
    chk("t6_conflict_rst", 64'(conflict_count), 64'd0);
    #2 rst_n = 1'b1;
    set_rd(2'b11, 12'h002, 12'h004);
    #1 chk("t6_ptr_reset_grant", 64'(rd_ready), 64'h2);
    chk("t6_wr_ready", 64'(wr_ready), 64'h1);
    tick();
    set_rd(2'b00, 12'h000, 12'h000);
    #2 rst_n = 1'b0;
    #1 chk("t6_inflight_rst", 64'(rsp_valid), 64'h0);
    #2 rst_n = 1'b1;
    tick();
    tick();
    chk("t6_inflight_dropped", 64'(rsp_valid), 64'h0);

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end
endmodule

// File: doc/voxel_memory_banked.md
Name: voxel_memory_banked

Overview:
Multi-port, banked voxel store for 2^COORD_BITS cubed grids, successor to the single-port 64^3 voxel RAM.
- NUM_RD independent read ports with valid/ready handshakes.
- One byte-masked write port with write-first forwarding.
- Per-bank round-robin conflict arbitration.
- A hardware clear engine that floods the whole volume with CLEAR_VALUE.
- Sits between the raymarch/fetch units (read ports) and the voxel update/DMA path (write port).

Parameters:
- DATA_WIDTH, 64, voxel word width; multiple of 8.
- COORD_BITS, 6, bits per axis; grid is 2^COORD_BITS per side; ADDR_WIDTH = 3*COORD_BITS (localparam).
- NUM_RD, 2, number of read ports, 1..4.
- BANK_BITS, 1, log2 of bank count; bank = addr[BANK_BITS-1:0] (low z bits), row = addr >> BANK_BITS.
- CLEAR_VALUE, 0, word written by the clear engine.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rd_valid  in  NUM_RD  per-port read request
- rd_addr  in  NUM_RD*ADDR_WIDTH  per-port address, port p at [p*ADDR_WIDTH +: ADDR_WIDTH], layout {x,y,z}
- rd_ready  out  NUM_RD  per-port request accepted this cycle
- rsp_valid  out  NUM_RD  per-port response valid
- rsp_data  out  NUM_RD*DATA_WIDTH  per-port response data
- wr_valid  in  1  write request
- wr_ready  out  1  write accepted
- wr_addr  in  ADDR_WIDTH  write address
- wr_data  in  DATA_WIDTH  write data
- wr_be  in  DATA_WIDTH/8  byte enables
- clear_start  in  1  pulse: start full-volume clear
- busy  out  1  clear in progress
- conflict_count  out  32  bank-conflict stall counter (see Optional Feature)

Behaviour:
- Clocking/reset: single clock clk; reset rst_n is asynchronous, active-low. Reset values: rsp_valid=0, rsp_data=0, busy=0, conflict_count=0, FSM=IDLE, clear row counter=0, arbiter pointers=0. RAM contents are not reset.
- Banks: 2^BANK_BITS simple 1R1W RAMs, each DEPTH>>BANK_BITS deep, with NUM_RD read slots per bank per cycle collapsed to one, so each bank performs one read per cycle.
- Read arbitration, IDLE and clear_start=0:
  - For each bank, among ports with rd_valid whose address maps to that bank, grant exactly one.
  - Selection is round-robin: start at port (last_grant+1) mod NUM_RD, where last_grant is the per-bank pointer.
  - The pointer updates only on a grant.
  - rd_ready[p] = grant[p]. It is combinational from rd_valid/rd_addr and may fall with valid held.
- Read latency: request accepted at edge T, then rsp_valid[p]=1 for exactly one cycle after edge T+2, with rsp_data[p] holding the word. rsp_data holds its last value when rsp_valid=0. Fully pipelined: one accept per port per cycle.
- Ordering: responses return in order per port.
- Write: wr_ready = !busy && !clear_start. Write accepted at edge T updates only the enabled bytes. Writes never conflict with reads.
- Forwarding: a read accepted at the same edge as a write to the same address returns the byte-merged new word (write-first per byte). A read accepted at T sees all writes accepted at or before T and none after.
- Clear FSM, IDLE -> CLEAR -> IDLE:
  - clear_start sampled in IDLE moves to CLEAR at the next edge. During that cycle rd_ready=0 and wr_ready=0.
  - In CLEAR: busy=1, all rd_ready=0, wr_ready=0. Every bank writes CLEAR_VALUE at row counter r each cycle; r increments from 0 to (DEPTH>>BANK_BITS)-1.
  - At r = max: return to IDLE and reset r to 0. Clear takes DEPTH>>BANK_BITS cycles; busy falls on the edge after the last row write.
  - clear_start in CLEAR is ignored.
  - Reads accepted before clear_start return pre-clear data.
  - Clear writes are never forwarded.
- rst_n asserted mid-clear aborts to IDLE with busy=0. Partially cleared contents are undefined. In-flight responses are dropped (rsp_valid=0).
- Widths: address compare is full ADDR_WIDTH. Counters wrap-free by construction.

Optional Feature:
- Macro: VOXEL_MEM_CONFLICT_STATS_EN.
- Defined: conflict_count increments by the number of ports that have rd_valid=1 and rd_ready=0 in IDLE (bank losers only, not clear stalls). It is 32-bit saturating at 0xFFFFFFFF and reset to 0.
- Undefined: conflict_count is tied to 0 and no counter logic is generated. All other behaviour is identical.

Test Plan:
1. Write addr 0x00105, data 0x1122334455667788, be=0xFF; then port0 reads 0x00105 -> rsp_valid[0] two cycles after accept, rsp_data[0]=0x1122334455667788.
2. Same-edge write to 0x00200 with be=0x0F, data 0xAAAAAAAABBBBBBBB, over old 0x0 and concurrent port1 read of 0x00200 -> rsp_data[1]=0x00000000BBBBBBBB.
3. Both ports hold rd_valid to bank 0 (addrs 0x00002, 0x00004) for 4 cycles -> grants alternate port0, port1, port0, port1. With VOXEL_MEM_CONFLICT_STATS_EN, conflict_count=4.
4. Ports read different banks (0x00002, 0x00003) simultaneously -> both rd_ready=1 the same cycle, both responses 2 cycles later.
5. clear_start pulse with CLEAR_VALUE=0xDEAD -> busy high for 131072 cycles (defaults), rd_ready/wr_ready low throughout; then reads of 0x00000 and 0x3FFFF return 0xDEAD.
6. rst_n low at cycle 1000 of a clear -> busy=0 and rsp_valid=0 immediately (asynchronous); after release, rd_ready=1 for a valid request.
